// File: rtl/decode_stage_hz_unit_if.sv
// Signal bundle between the IF/ID side, the forwarding/write-back sources and the decode stage.
// Use the master modport on the driving side and the slave modport on the decode stage.
interface decode_stage_hz_unit_if #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned NUM_REGS = 32
);
    localparam int unsigned REG_AW = $clog2(NUM_REGS);

    logic              if_valid;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              reg2loc;
    logic              uncond_br;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic [1:0]        fw_sel1;
    logic [1:0]        fw_sel2;
    logic [DATA_W-1:0] fwd_alu;
    logic [DATA_W-1:0] fwd_mem;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              hz_stall;
    logic              rd_zero;
    logic [ADDR_W-1:0] br_target;
    logic              id_valid;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [31:0]       stall_cnt;

    modport master (
        output if_valid, if_instr, if_pc, reg2loc, uncond_br, ex_mem_read, ex_rd,
               fw_sel1, fw_sel2, fwd_alu, fwd_mem, wb_en, wb_addr, wb_data, flush,
        input  hz_stall, rd_zero, br_target, id_valid, id_rdata1, id_rdata2, id_instr,
               id_pc, stall_cnt
    );

    modport slave (
        input  if_valid, if_instr, if_pc, reg2loc, uncond_br, ex_mem_read, ex_rd,
               fw_sel1, fw_sel2, fwd_alu, fwd_mem, wb_en, wb_addr, wb_data, flush,
        output hz_stall, rd_zero, br_target, id_valid, id_rdata1, id_rdata2, id_instr,
               id_pc, stall_cnt
    );
endinterface

// File: rtl/decode_stage_hz_unit.sv
// Decode stage: register file with write-through bypass, operand forwarding, early branch
// target, load-use hazard detection and the ID/EX pipeline register.
module decode_stage_hz_unit #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ZERO_REG = 31
) (
    input logic                 clk,
    input logic                 reset,
    decode_stage_hz_unit_if.slave bus
);
    localparam int unsigned REG_AW = $clog2(NUM_REGS);
    localparam logic [REG_AW-1:0] ZeroIdx = REG_AW'(ZERO_REG);

    logic [DATA_W-1:0] regFile [NUM_REGS];
    logic [REG_AW-1:0] rs1, rs2;
    logic [DATA_W-1:0] rfData1, rfData2, opnd1, opnd2;
    logic [ADDR_W-1:0] brOffset;

    logic              idValidQ;
    logic [DATA_W-1:0] idRdata1Q, idRdata2Q;
    logic [31:0]       idInstrQ;
    logic [ADDR_W-1:0] idPcQ;
    logic [31:0]       stallCntQ;

    assign rs1 = REG_AW'(bus.if_instr[9:5]);
    assign rs2 = bus.reg2loc ? REG_AW'(bus.if_instr[20:16]) : REG_AW'(bus.if_instr[4:0]);

    // Zero register check comes last so it also masks the write-back bypass.
    always_comb begin
        rfData1 = regFile[rs1];
        rfData2 = regFile[rs2];
        if (bus.wb_en && bus.wb_addr == rs1) rfData1 = bus.wb_data;
        if (bus.wb_en && bus.wb_addr == rs2) rfData2 = bus.wb_data;
        if (rs1 == ZeroIdx) rfData1 = '0;
        if (rs2 == ZeroIdx) rfData2 = '0;
    end

    always_comb begin
        opnd1 = rfData1;
        opnd2 = rfData2;
        case (bus.fw_sel1)
            2'b01:   opnd1 = bus.fwd_alu;
            2'b10:   opnd1 = bus.fwd_mem;
            default: opnd1 = rfData1;
        endcase
        case (bus.fw_sel2)
            2'b01:   opnd2 = bus.fwd_alu;
            2'b10:   opnd2 = bus.fwd_mem;
            default: opnd2 = rfData2;
        endcase
    end

    always_comb begin
        if (bus.uncond_br) brOffset = {{(ADDR_W-26){bus.if_instr[25]}}, bus.if_instr[25:0]};
        else               brOffset = {{(ADDR_W-19){bus.if_instr[23]}}, bus.if_instr[23:5]};
    end

    assign bus.br_target = bus.if_pc + (brOffset << 2);
    assign bus.rd_zero   = (opnd2 == '0);
    assign bus.hz_stall  = bus.if_valid && bus.ex_mem_read && (bus.ex_rd != ZeroIdx) &&
                           ((bus.ex_rd == rs1) || (bus.ex_rd == rs2));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regFile[i] <= '0;
        end else if (bus.wb_en && bus.wb_addr != ZeroIdx) begin
            regFile[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Flush and stall both leave a bubble; data fields keep their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            idValidQ  <= 1'b0;
            idRdata1Q <= '0;
            idRdata2Q <= '0;
            idInstrQ  <= '0;
            idPcQ     <= '0;
        end else if (bus.flush || bus.hz_stall) begin
            idValidQ  <= 1'b0;
        end else begin
            idValidQ  <= bus.if_valid;
            idRdata1Q <= opnd1;
            idRdata2Q <= opnd2;
            idInstrQ  <= bus.if_instr;
            idPcQ     <= bus.if_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCntQ <= '0;
        end else if (bus.hz_stall && !bus.flush && stallCntQ != '1) begin
            stallCntQ <= stallCntQ + 32'd1;
        end
    end

    assign bus.id_valid  = idValidQ;
    assign bus.id_rdata1 = idRdata1Q;
    assign bus.id_rdata2 = idRdata2Q;
    assign bus.id_instr  = idInstrQ;
    assign bus.id_pc     = idPcQ;
    assign bus.stall_cnt = stallCntQ;
endmodule

// File: tb/tb_decode_stage_hz_unit.sv
// Directed bench for the decode stage: regfile/bypass, forwarding, branch target,
// load-use hazard, flush and reset behaviour.
module tb_decode_stage_hz_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    decode_stage_hz_unit_if #(.DATA_W(64), .ADDR_W(64), .NUM_REGS(32)) hzIf ();

    decode_stage_hz_unit #(
        .DATA_W(64), .ADDR_W(64), .NUM_REGS(32), .ZERO_REG(31)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (hzIf)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rs1 at [9:5], rs2 at [20:16] (reg2loc=1) and [4:0] (reg2loc=0)
    function automatic logic [31:0] mkInstr(input logic [4:0] r1, input logic [4:0] rHi,
                                            input logic [4:0] rLo);
        logic [31:0] w;
        w        = 32'h0;
        w[9:5]   = r1;
        w[20:16] = rHi;
        w[4:0]   = rLo;
        return w;
    endfunction

    initial begin
        hzIf.if_valid = 0; hzIf.if_instr = 0; hzIf.if_pc = 0; hzIf.reg2loc = 1;
        hzIf.uncond_br = 0; hzIf.ex_mem_read = 0; hzIf.ex_rd = 0; hzIf.fw_sel1 = 0;
        hzIf.fw_sel2 = 0; hzIf.fwd_alu = 0; hzIf.fwd_mem = 0; hzIf.wb_en = 0;
        hzIf.wb_addr = 0; hzIf.wb_data = 0; hzIf.flush = 0;

        tick(); tick();
        checkVal("rst_valid", 64'(hzIf.id_valid), 64'd0);
        checkVal("rst_cnt", 64'(hzIf.stall_cnt), 64'd0);
        checkVal("rst_rdata1", hzIf.id_rdata1, 64'd0);
        reset = 0;

        // X5 reads 0 after reset
        hzIf.if_valid = 1; hzIf.if_instr = mkInstr(5, 5, 0); hzIf.if_pc = 64'h40;
        #1 checkVal("x5_zero_rdzero", 64'(hzIf.rd_zero), 64'd1);
        tick();
        checkVal("x5_valid", 64'(hzIf.id_valid), 64'd1);
        checkVal("x5_rdata1", hzIf.id_rdata1, 64'd0);
        checkVal("x5_pc", hzIf.id_pc, 64'h40);
        checkVal("x5_instr", 64'(hzIf.id_instr), 64'(mkInstr(5, 5, 0)));

        // same-cycle write-through
        hzIf.wb_en = 1; hzIf.wb_addr = 5; hzIf.wb_data = 64'hABCD;
        #1 checkVal("bypass_rdzero", 64'(hzIf.rd_zero), 64'd0);
        tick();
        checkVal("bypass_rdata1", hzIf.id_rdata1, 64'hABCD);
        checkVal("bypass_rdata2", hzIf.id_rdata2, 64'hABCD);
        hzIf.wb_en = 0;
        tick();
        checkVal("rf_rdata1", hzIf.id_rdata1, 64'hABCD);

        // zero register ignores writes and bypass
        hzIf.wb_en = 1; hzIf.wb_addr = 31; hzIf.wb_data = 64'h1234;
        hzIf.if_instr = mkInstr(31, 31, 0);
        #1 checkVal("x31_bypass_rdzero", 64'(hzIf.rd_zero), 64'd1);
        tick();
        checkVal("x31_bypass_rdata1", hzIf.id_rdata1, 64'd0);
        hzIf.wb_en = 0;
        tick();
        checkVal("x31_rf_rdata1", hzIf.id_rdata1, 64'd0);
        checkVal("x31_rf_rdata2", hzIf.id_rdata2, 64'd0);

        // forwarding selects
        hzIf.if_instr = mkInstr(5, 5, 0);
        hzIf.fw_sel1 = 2'b01; hzIf.fwd_alu = 64'h55; hzIf.fw_sel2 = 2'b10; hzIf.fwd_mem = 64'h77;
        tick();
        checkVal("fwd_alu", hzIf.id_rdata1, 64'h55);
        checkVal("fwd_mem", hzIf.id_rdata2, 64'h77);
        hzIf.fw_sel1 = 2'b11; hzIf.fw_sel2 = 2'b00;
        tick();
        checkVal("fwd_11_rf", hzIf.id_rdata1, 64'hABCD);
        checkVal("fwd_00_rf", hzIf.id_rdata2, 64'hABCD);
        hzIf.fw_sel1 = 0;

        // load-use hazard
        hzIf.ex_mem_read = 1; hzIf.ex_rd = 3; hzIf.if_instr = mkInstr(3, 0, 0);
        #1 checkVal("hz_rs1", 64'(hzIf.hz_stall), 64'd1);
        tick();
        checkVal("hz_bubble", 64'(hzIf.id_valid), 64'd0);
        checkVal("hz_cnt", 64'(hzIf.stall_cnt), 64'd1);
        hzIf.ex_rd = 31; hzIf.if_instr = mkInstr(31, 0, 0);
        #1 checkVal("hz_x31", 64'(hzIf.hz_stall), 64'd0);
        hzIf.ex_rd = 7; hzIf.if_instr = mkInstr(1, 0, 7); hzIf.reg2loc = 0;
        #1 checkVal("hz_rs2_lo", 64'(hzIf.hz_stall), 64'd1);
        hzIf.reg2loc = 1;
        #1 checkVal("hz_rs2_hi", 64'(hzIf.hz_stall), 64'd0);
        hzIf.reg2loc = 0; hzIf.if_valid = 0;
        #1 checkVal("hz_invalid", 64'(hzIf.hz_stall), 64'd0);
        hzIf.reg2loc = 1; hzIf.if_valid = 1; hzIf.ex_mem_read = 0;

        // branch target
        hzIf.if_pc = 64'h100; hzIf.uncond_br = 1; hzIf.if_instr = 32'h03FF_FFFE;
        #1 checkVal("br_imm26_neg", hzIf.br_target, 64'hF8);
        hzIf.uncond_br = 0; hzIf.if_instr = 32'h0000_0080;
        #1 checkVal("br_imm19_pos", hzIf.br_target, 64'h110);
        hzIf.if_instr = 32'h00FF_FFE0;
        #1 checkVal("br_imm19_neg", hzIf.br_target, 64'hFC);
        hzIf.if_pc = 64'h0; hzIf.uncond_br = 1; hzIf.if_instr = 32'h03FF_FFFF;
        #1 checkVal("br_wrap", hzIf.br_target, 64'hFFFF_FFFF_FFFF_FFFC);
        hzIf.uncond_br = 0;

        // rd_zero from forwarded operand 2
        hzIf.if_instr = mkInstr(5, 5, 0); hzIf.fw_sel2 = 2'b01; hzIf.fwd_alu = 64'h0;
        #1 checkVal("rdzero_fwd0", 64'(hzIf.rd_zero), 64'd1);
        hzIf.fwd_alu = 64'h1;
        #1 checkVal("rdzero_fwd1", 64'(hzIf.rd_zero), 64'd0);
        hzIf.fw_sel2 = 0;

        // flush together with stall
        hzIf.if_pc = 64'h200;
        tick();
        checkVal("pre_flush_valid", 64'(hzIf.id_valid), 64'd1);
        hzIf.if_pc = 64'h300; hzIf.ex_mem_read = 1; hzIf.ex_rd = 5; hzIf.flush = 1;
        #1 checkVal("flush_hz", 64'(hzIf.hz_stall), 64'd1);
        tick();
        checkVal("flush_valid", 64'(hzIf.id_valid), 64'd0);
        checkVal("flush_cnt", 64'(hzIf.stall_cnt), 64'd1);
        checkVal("flush_pc_held", hzIf.id_pc, 64'h200);
        hzIf.flush = 0;

        // reset mid-operation wins over a pending stall
        hzIf.if_pc = 64'h400; reset = 1;
        tick();
        checkVal("mrst_cnt", 64'(hzIf.stall_cnt), 64'd0);
        checkVal("mrst_valid", 64'(hzIf.id_valid), 64'd0);
        checkVal("mrst_pc", hzIf.id_pc, 64'd0);
        reset = 0; hzIf.ex_mem_read = 0;
        #1 checkVal("mrst_x5_cleared", 64'(hzIf.rd_zero), 64'd1);
        tick();
        checkVal("mrst_resume_valid", 64'(hzIf.id_valid), 64'd1);
        checkVal("mrst_resume_rdata1", hzIf.id_rdata1, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
